data_store_fifo: RTL and testbench
==================================

# data_store_fifo

Committed-store buffer between the commit stage and the data memory write port. Accepts at most one committed store per cycle, buffers up to DEPTH entries in order, converts each to a word-aligned address, lane-replicated write data and byte strobes, and drains them to memory over a valid/ready handshake. It also flags loads that overlap a pending store so that the load path can stall.

## Interface
- DEPTH, 4, number of entries; power of two, minimum 2
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- datafifo_addr_in  input  32  store byte address
- datafifo_val_in  input  32  store data, right-justified
- datafifo_size_in  input  2  0 = byte, 1 = half, 2 = word, 3 = treated as word
- datafifo_valid_in  input  1  push request
- datafifo_full  output  1  no free entry
- datafifo_empty  output  1  no pending entry; used for fences
- mem_waddr  output  32  word address, bits [1:0] forced to 0
- mem_wdata  output  32  lane-replicated write data
- mem_wstrb  output  4  byte enables
- mem_wvalid  output  1  head entry is presented
- mem_wready  input  1  memory accepts the head entry
- load_addr_in  input  32  address of the load currently in execute
- load_conflict  output  1  load word overlaps a pending store

## Operation
- Circular buffer with head and tail pointers of log2(DEPTH) bits plus an occupancy count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Push: datafifo_valid_in && !datafifo_full. Writes the entry at tail and increments tail.
- A push while full is ignored with no state change. The commit stage never issues one.
- Pop: mem_wvalid && mem_wready. Increments head.
- Count update: push only +1, pop only −1, both unchanged.
- Encoding at push time, from addr[1:0] = a:
  - byte: strb = 1 << a, data = {4{val[7:0]}}
  - half: strb = 4'b0011 << {a[1],1'b0}, data = {2{val[15:0]}}
  - word/3: strb = 4'hF, data = val
  - Misalignment is caught upstream. The block ignores a[0] for half-word stores and a[1:0] for word stores.
- mem_waddr, mem_wdata and mem_wstrb come from the head entry. All three are 0 while empty.
- pipeline_flush has no effect on this block, because committed stores are never discarded.
- load_conflict = OR over all occupied entries of (entry_addr[31:2] == load_addr_in[31:2]). It is combinational, and 0 while empty.

## Timing
- Reset values: datafifo_full=0, datafifo_empty=1, mem_wvalid=0, mem_waddr=0, mem_wdata=0, mem_wstrb=0, load_conflict=0, pointers=0, count=0.
- Reset mid-drain discards all entries, including a head entry being presented. Storage contents need not be cleared.
- datafifo_full = (count == DEPTH) and datafifo_empty = (count == 0). Both are decoded from registers only, with no combinational path from any input.
- There is no fall-through. A push is visible on mem_wvalid one cycle later at the earliest.
- Push and pop in the same cycle while full: the push is rejected, because full is evaluated before the pop. The pop completes, and full deasserts the next cycle.
- Push and pop in the same cycle while count is between 1 and DEPTH−1: both occur and count is unchanged.
- mem_* outputs are held stable while mem_wvalid && !mem_wready. On a pop, the next entry is presented in the following cycle, allowing back-to-back drains at one store per cycle.
- An entry pushed in cycle N participates in load_conflict from cycle N+1. It stops participating in the cycle after it pops.

## Configuration
- DATAFIFO_LOAD_CONFLICT_EN
  - Defined: load_conflict uses the per-entry word-address compare described above.
  - Undefined: the comparators are omitted and load_conflict = !datafifo_empty, so any pending store stalls every load.

## Test plan
- Reset, then a word store (0x1000, 0xDEADBEEF) with mem_wready=1: the next cycle shows mem_waddr=0x1000, wdata=0xDEADBEEF, wstrb=F, wvalid=1. The cycle after that, empty=1.
- Byte store at 0x2003, val 0x000000AB: wdata=0xABABABAB, wstrb=4'b1000, waddr=0x2000. Half store at 0x2002, val 0x1234: wdata=0x12341234, wstrb=4'b1100.
- Hold mem_wready=0 and push 4 stores: full=1 after the 4th, and a 5th push is ignored. Set ready=1: four stores drain in order on consecutive cycles, then empty=1.
- When full, push and pop in the same cycle: the push is dropped, count becomes 3, and full=0 the next cycle.
- Pending store at 0x3004 with ready=0: load_addr=0x3006 gives load_conflict=1 and load_addr=0x3008 gives 0. With the macro undefined, both give 1.
- Assert reset with 3 entries pending and ready=0: the next cycle shows empty=1, wvalid=0 and all mem outputs 0.

Source files
------------

// File: rtl/data_store_fifo_if.sv
// Bundle between commit stage, data-store FIFO, data memory write port and load path.
// The slave modport is the FIFO; the master modport is its surroundings.
interface data_store_fifo_if;
  logic [31:0] datafifo_addr_in;
  logic [31:0] datafifo_val_in;
  logic [1:0]  datafifo_size_in;
  logic        datafifo_valid_in;
  logic        datafifo_full;
  logic        datafifo_empty;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [31:0] load_addr_in;
  logic        load_conflict;

  modport master (
    output datafifo_addr_in, datafifo_val_in, datafifo_size_in, datafifo_valid_in,
    input  datafifo_full, datafifo_empty,
    input  mem_waddr, mem_wdata, mem_wstrb, mem_wvalid,
    output mem_wready,
    output load_addr_in,
    input  load_conflict
  );

  modport slave (
    input  datafifo_addr_in, datafifo_val_in, datafifo_size_in, datafifo_valid_in,
    output datafifo_full, datafifo_empty,
    output mem_waddr, mem_wdata, mem_wstrb, mem_wvalid,
    input  mem_wready,
    input  load_addr_in,
    output load_conflict
  );
endinterface

// File: rtl/data_store_fifo.sv
// Committed-store buffer draining to the data memory write port, with load-overlap detection.
// Define DATAFIFO_LOAD_CONFLICT_EN for per-entry word compare; otherwise any pending store stalls loads.
module data_store_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input logic              clk,
  input logic              reset,
  data_store_fifo_if.slave bus
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } entry_t;

  entry_t          store_q [DEPTH];
  entry_t          push_entry;
  entry_t          head_entry;
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full, empty, push, pop;
  logic            conflict;

  // Status comes only from the count register, so full/empty have no input paths.
  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.datafifo_valid_in && !full;
  assign pop   = !empty && bus.mem_wready;

  always_comb begin
    push_entry.waddr = bus.datafifo_addr_in[31:2];
    push_entry.wdata = bus.datafifo_val_in;
    push_entry.wstrb = 4'hF;
    unique case (bus.datafifo_size_in)
      2'd0: begin
        push_entry.wdata = {4{bus.datafifo_val_in[7:0]}};
        push_entry.wstrb = 4'b0001 << bus.datafifo_addr_in[1:0];
      end
      2'd1: begin
        push_entry.wdata = {2{bus.datafifo_val_in[15:0]}};
        push_entry.wstrb = 4'b0011 << {bus.datafifo_addr_in[1], 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    head_d  = pop  ? head_q + PtrW'(1) : head_q;
    tail_d  = push ? tail_q + PtrW'(1) : tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      store_q[tail_q] <= push_entry;
    end
  end

  assign head_entry = store_q[head_q];

  assign bus.datafifo_full  = full;
  assign bus.datafifo_empty = empty;
  assign bus.mem_wvalid     = !empty;
  assign bus.mem_waddr      = empty ? 32'h0 : {head_entry.waddr, 2'b00};
  assign bus.mem_wdata      = empty ? 32'h0 : head_entry.wdata;
  assign bus.mem_wstrb      = empty ? 4'h0  : head_entry.wstrb;

`ifdef DATAFIFO_LOAD_CONFLICT_EN
  logic unused_load_lsb;
  assign unused_load_lsb = ^bus.load_addr_in[1:0];

  // Slot i is occupied when its distance from head is below the count.
  always_comb begin
    conflict = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (({1'b0, PtrW'(PtrW'(i) - head_q)} < count_q) &&
          (store_q[i].waddr == bus.load_addr_in[31:2])) begin
        conflict = 1'b1;
      end
    end
  end
`else
  logic unused_load_addr;
  assign unused_load_addr = ^bus.load_addr_in;
  assign conflict = !empty;
`endif

  assign bus.load_conflict = conflict;

endmodule

// File: tb/tb_data_store_fifo.sv
// Directed self-checking bench for data_store_fifo (DEPTH = 4).
module tb_data_store_fifo;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  data_store_fifo_if bus ();

  data_store_fifo #(
    .DEPTH(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DATAFIFO_LOAD_CONFLICT_EN
  localparam logic CONFLICT_FAR = 1'b0;
`else
  localparam logic CONFLICT_FAR = 1'b1;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] addr, input logic [31:0] val, input logic [1:0] size);
    bus.datafifo_addr_in  = addr;
    bus.datafifo_val_in   = val;
    bus.datafifo_size_in  = size;
    bus.datafifo_valid_in = 1'b1;
  endtask

  task automatic idle();
    bus.datafifo_valid_in = 1'b0;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    chk({tag, "_wvalid"}, {31'b0, bus.mem_wvalid}, 32'd1);
    chk({tag, "_waddr"}, bus.mem_waddr, a);
    chk({tag, "_wdata"}, bus.mem_wdata, d);
    chk({tag, "_wstrb"}, {28'b0, bus.mem_wstrb}, {28'b0, s});
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_empty"}, {31'b0, bus.datafifo_empty}, 32'd1);
    chk({tag, "_full"}, {31'b0, bus.datafifo_full}, 32'd0);
    chk({tag, "_wvalid"}, {31'b0, bus.mem_wvalid}, 32'd0);
    chk({tag, "_waddr"}, bus.mem_waddr, 32'h0);
    chk({tag, "_wdata"}, bus.mem_wdata, 32'h0);
    chk({tag, "_wstrb"}, {28'b0, bus.mem_wstrb}, 32'h0);
    chk({tag, "_conflict"}, {31'b0, bus.load_conflict}, 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.datafifo_addr_in  = '0;
    bus.datafifo_val_in   = '0;
    bus.datafifo_size_in  = '0;
    bus.datafifo_valid_in = 1'b0;
    bus.mem_wready        = 1'b0;
    bus.load_addr_in      = '0;

    repeat (2) cyc();
    mid();
    chk_idle("reset");

    // Word store, drained immediately.
    cyc();
    reset = 1'b0;
    bus.mem_wready = 1'b1;
    push(32'h0000_1000, 32'hDEAD_BEEF, 2'd2);
    mid();
    chk("no_fallthrough", {31'b0, bus.mem_wvalid}, 32'd0);
    cyc();
    idle();
    mid();
    chk_head("word", 32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
    chk("word_empty", {31'b0, bus.datafifo_empty}, 32'd0);
    cyc();
    mid();
    chk("word_drained", {31'b0, bus.datafifo_empty}, 32'd1);

    // Byte then half, with memory stalled for a cycle.
    cyc();
    bus.mem_wready = 1'b0;
    push(32'h0000_2003, 32'h0000_00AB, 2'd0);
    cyc();
    push(32'h0000_2002, 32'h0000_1234, 2'd1);
    mid();
    chk_head("byte", 32'h0000_2000, 32'hABAB_ABAB, 4'b1000);
    cyc();
    idle();
    bus.mem_wready = 1'b1;
    mid();
    chk_head("byte_hold", 32'h0000_2000, 32'hABAB_ABAB, 4'b1000);
    cyc();
    mid();
    chk_head("half", 32'h0000_2000, 32'h1234_1234, 4'b1100);
    cyc();
    bus.mem_wready = 1'b0;
    mid();
    chk("half_drained", {31'b0, bus.datafifo_empty}, 32'd1);

    // Fill to DEPTH with memory stalled (slots wrap around the end of storage).
    for (int k = 0; k < 4; k++) begin
      push(32'h0000_4000 + 32'(4 * k), 32'h1111_1111 * 32'(k + 1), 2'd2);
      cyc();
    end
    push(32'h0000_5000, 32'h5555_5555, 2'd2);
    mid();
    chk("fill_full", {31'b0, bus.datafifo_full}, 32'd1);
    chk_head("fill_head", 32'h0000_4000, 32'h1111_1111, 4'hF);
    cyc();
    // Push-while-full dropped; now push and pop together while full.
    push(32'h0000_6000, 32'h6666_6666, 2'd2);
    bus.mem_wready = 1'b1;
    mid();
    chk("full_after_drop", {31'b0, bus.datafifo_full}, 32'd1);
    chk_head("head_after_drop", 32'h0000_4000, 32'h1111_1111, 4'hF);
    cyc();
    idle();
    mid();
    chk("full_cleared", {31'b0, bus.datafifo_full}, 32'd0);
    chk_head("drain1", 32'h0000_4004, 32'h2222_2222, 4'hF);
    cyc();
    mid();
    chk_head("drain2", 32'h0000_4008, 32'h3333_3333, 4'hF);
    cyc();
    mid();
    chk_head("drain3", 32'h0000_400C, 32'h4444_4444, 4'hF);
    cyc();
    mid();
    chk("drain_empty", {31'b0, bus.datafifo_empty}, 32'd1);

    // Load conflict against a stalled store at 0x3004.
    cyc();
    bus.mem_wready   = 1'b0;
    bus.load_addr_in = 32'h0000_3004;
    push(32'h0000_3004, 32'hCAFE_F00D, 2'd2);
    mid();
    chk("conflict_same_cycle", {31'b0, bus.load_conflict}, 32'd0);
    cyc();
    idle();
    bus.load_addr_in = 32'h0000_3006;
    #1;
    chk("conflict_near", {31'b0, bus.load_conflict}, 32'd1);
    bus.load_addr_in = 32'h0000_3008;
    #1;
    chk("conflict_far", {31'b0, bus.load_conflict}, {31'b0, CONFLICT_FAR});

    // Reset with three entries pending.
    bus.load_addr_in = 32'h0000_3004;
    push(32'h0000_7000, 32'h7070_7070, 2'd2);
    cyc();
    push(32'h0000_7004, 32'h7171_7171, 2'd2);
    cyc();
    idle();
    reset = 1'b1;
    mid();
    chk_head("pre_reset", 32'h0000_3004, 32'hCAFE_F00D, 4'hF);
    cyc();
    reset = 1'b0;
    mid();
    chk_idle("mid_reset");

    // Pointers restart cleanly after reset.
    cyc();
    bus.mem_wready = 1'b1;
    push(32'h0000_8001, 32'h0000_00CD, 2'd0);
    cyc();
    idle();
    mid();
    chk_head("post_reset", 32'h0000_8000, 32'hCDCD_CDCD, 4'b0010);
    cyc();
    mid();
    chk("post_reset_empty", {31'b0, bus.datafifo_empty}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
